// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM state encoding and default bus widths.
// Pure declarations, no logic.
package fetch_stage_pkg;
    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 32;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = FETCH,
        S_HOLD  = HOLD,
        S_DRAIN = DRAIN
    } state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory, decode handoff and redirect.
// master = fetch stage; slave = memory/decode/redirect side.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               mem_rd;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               id_ready;

    modport master (
        input  redirect_valid, redirect_pc, mem_rdata, mem_ack, id_ready,
        output mem_rd, mem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_rdata, mem_ack, id_ready,
        input  mem_rd, mem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: redirect load beats increment; wraps modulo 2^PC_W.
// Latency: one cycle; no backpressure.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding read, registered IF/ID output, redirect drains stale reads.
// Latency: ack+1 cycles per instruction; holds output while decode stalls (id_ready=0).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    state_e             state_q, state_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
    logic [PC_W-1:0]    pc;
    logic               pc_inc;

    pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (bus.redirect_valid),
        .load_pc (bus.redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    always_comb begin
        state_d      = state_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        drain_addr_d = drain_addr_q;
        pc_inc       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    if_valid_d = 1'b0;
                    // Request still in flight: remember its address so mem_addr stays stable.
                    if (!bus.mem_ack) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc;
                    end
                end else if (bus.mem_ack) begin
                    if_instr_d = bus.mem_rdata;
                    if_pc_d    = pc;
                    if_valid_d = 1'b1;
                    pc_inc     = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid || bus.id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (bus.redirect_valid) begin
                    if_valid_d = 1'b0;
                end
                if (bus.mem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d    = S_FETCH;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Reset gates the request combinationally so it drops the instant rst_n falls.
    assign bus.mem_rd   = rst_n && (state_q != S_HOLD);
    assign bus.mem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc;
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory acks one cycle after a request with rdata=A000_0000+addr.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic rst_n;
    logic mem_en;
    int   checks;
    int   errors;
    int   cyc;
    int   last_valid_cyc;
    int   gap;
    int   age;

    fetch_stage_if #(.PC_W(16), .INSTR_W(32)) bus ();

    fetch_stage #(
        .PC_W     (16),
        .INSTR_W  (32),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks on the second negedge a request is seen, one-cycle pulse.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        age           = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                age         = 0;
            end else if (bus.mem_rd) begin
                age++;
                if (age >= 2 && mem_en) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'hA000_0000 + {16'h0000, bus.mem_addr};
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.if_valid && n < 20);
        chk({tag, "_seen"}, {31'd0, bus.if_valid}, 32'd1);
        gap            = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        cyc                = 0;
        last_valid_cyc     = 0;
        gap                = 0;
        mem_en             = 1'b1;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;

        step();
        step();
        chk("rst_mem_rd",   {31'd0, bus.mem_rd},   32'd0);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_pc",    {16'd0, bus.if_pc},    32'd0);
        chk("rst_if_instr", bus.if_instr,          32'd0);
        chk("rst_state",    {30'd0, dut.state_q},  {30'd0, FETCH});

        rst_n = 1'b1;
        #1;
        chk("first_req_rd",   {31'd0, bus.mem_rd}, 32'd1);
        chk("first_req_addr", {16'd0, bus.mem_addr}, 32'h0000);

        // Sequential fetch with decode always ready
        wait_valid("v0");
        chk("v0_pc",    {16'd0, bus.if_pc}, 32'h0000);
        chk("v0_instr", bus.if_instr,       32'hA000_0000);
        wait_valid("v1");
        chk("v1_pc",    {16'd0, bus.if_pc}, 32'h0001);
        chk("v1_instr", bus.if_instr,       32'hA000_0001);
        chk("v1_gap",   gap,                32'd3);

        // Stall decode on instruction 2
        step();
        bus.id_ready = 1'b0;
        wait_valid("v2");
        chk("v2_pc",    {16'd0, bus.if_pc}, 32'h0002);
        chk("v2_instr", bus.if_instr,       32'hA000_0002);
        chk("v2_gap",   gap,                32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, bus.if_valid},   32'd1);
            chk("stall_pc",    {16'd0, bus.if_pc},      32'h0002);
            chk("stall_instr", bus.if_instr,            32'hA000_0002);
            chk("stall_rd",    {31'd0, bus.mem_rd},     32'd0);
            chk("stall_pcreg", {16'd0, dut.u_pc.pc_q},  32'h0003);
        end
        bus.id_ready = 1'b1;

        wait_valid("v3");
        chk("v3_pc",    {16'd0, bus.if_pc}, 32'h0003);
        chk("v3_instr", bus.if_instr,       32'hA000_0003);
        wait_valid("v4");
        chk("v4_pc",    {16'd0, bus.if_pc}, 32'h0004);
        chk("v4_gap",   gap,                32'd3);

        // Redirect while the request for 5 is outstanding
        mem_en = 1'b0;
        step();
        chk("req5_rd",   {31'd0, bus.mem_rd},   32'd1);
        chk("req5_addr", {16'd0, bus.mem_addr}, 32'h0005);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        step();
        bus.redirect_valid = 1'b0;
        chk("drain_state", {30'd0, dut.state_q},   {30'd0, DRAIN});
        chk("drain_addr",  {16'd0, bus.mem_addr},  32'h0005);
        chk("drain_rd",    {31'd0, bus.mem_rd},    32'd1);
        chk("drain_pcreg", {16'd0, dut.u_pc.pc_q}, 32'h0040);
        step();
        chk("drain_addr_hold", {16'd0, bus.mem_addr}, 32'h0005);
        mem_en = 1'b1;
        step();
        chk("drain_ack",     {31'd0, bus.mem_ack},  32'd1);
        chk("drain_ack_adr", {16'd0, bus.mem_addr}, 32'h0005);
        step();
        chk("post_drain_state", {30'd0, dut.state_q},  {30'd0, FETCH});
        chk("post_drain_addr",  {16'd0, bus.mem_addr}, 32'h0040);
        chk("post_drain_valid", {31'd0, bus.if_valid}, 32'd0);
        wait_valid("v40");
        chk("v40_pc",    {16'd0, bus.if_pc}, 32'h0040);
        chk("v40_instr", bus.if_instr,       32'hA000_0040);

        // Redirect coincident with mem_ack
        step();
        step();
        chk("coinc_ack", {31'd0, bus.mem_ack}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        step();
        bus.redirect_valid = 1'b0;
        chk("coinc_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("coinc_addr",  {16'd0, bus.mem_addr}, 32'h0100);
        chk("coinc_rd",    {31'd0, bus.mem_rd},   32'd1);
        wait_valid("v100");
        chk("v100_pc",    {16'd0, bus.if_pc}, 32'h0100);
        chk("v100_instr", bus.if_instr,       32'hA000_0100);

        // Redirect to top of address space, PC wraps
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr", {16'd0, bus.mem_addr}, 32'hFFFF);
        wait_valid("vffff");
        chk("vffff_pc",    {16'd0, bus.if_pc}, 32'hFFFF);
        chk("vffff_instr", bus.if_instr,       32'hA000_FFFF);
        wait_valid("vwrap");
        chk("vwrap_pc",    {16'd0, bus.if_pc}, 32'h0000);
        chk("vwrap_instr", bus.if_instr,       32'hA000_0000);

        // Reset pulse in the middle of DRAIN
        mem_en = 1'b0;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0200;
        step();
        bus.redirect_valid = 1'b0;
        chk("rst2_drain", {30'd0, dut.state_q}, {30'd0, DRAIN});
        chk("rst2_rd_pre", {31'd0, bus.mem_rd}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_rd",    {31'd0, bus.mem_rd},    32'd0);
        chk("rst2_valid", {31'd0, bus.if_valid},  32'd0);
        chk("rst2_state", {30'd0, dut.state_q},   {30'd0, FETCH});
        chk("rst2_pcreg", {16'd0, dut.u_pc.pc_q}, 32'h0000);
        chk("rst2_if_pc", {16'd0, bus.if_pc},     32'h0000);
        step();
        step();
        rst_n  = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("rst2_req_rd",   {31'd0, bus.mem_rd},   32'd1);
        chk("rst2_req_addr", {16'd0, bus.mem_addr}, 32'h0000);
        wait_valid("vr0");
        chk("vr0_pc",    {16'd0, bus.if_pc}, 32'h0000);
        chk("vr0_instr", bus.if_instr,       32'hA000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 16, program-counter and memory-address width in words.
REQ-002 Parameter INSTR_W, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 redirect_valid  input  1  branch/jump redirect request from a later stage.
REQ-007 redirect_pc  input  PC_W  redirect target, sampled when redirect_valid=1.
REQ-008 mem_rd  output  1  instruction-memory read request, held until mem_ack.
REQ-009 mem_addr  output  PC_W  instruction-memory word address.
REQ-010 mem_rdata  input  INSTR_W  instruction word, valid when mem_ack=1.
REQ-011 mem_ack  input  1  read completion, one-cycle pulse, earliest the cycle after mem_rd rises.
REQ-012 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction for decode.
REQ-013 if_instr  output  INSTR_W  fetched instruction to decode.
REQ-014 if_pc  output  PC_W  address of if_instr.
REQ-015 id_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-016 The stage SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-017 In FETCH, mem_rd=1 and mem_addr=pc; in DRAIN, mem_rd=1 and mem_addr=the stale outstanding address; in HOLD, mem_rd=0.
REQ-018 FETCH with mem_ack=1 and no redirect SHALL register if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1, and go to HOLD.
REQ-019 HOLD with id_ready=1 SHALL clear if_valid and go to FETCH next cycle. Throughput is one instruction per ack+1 cycles.
REQ-020 HOLD with id_ready=0 SHALL keep if_valid, if_instr and if_pc bit-stable.
REQ-021 redirect_valid SHALL have highest priority: pc<=redirect_pc and if_valid<=0 in the same edge.
REQ-022 Redirect in FETCH without mem_ack SHALL move to DRAIN. Redirect in FETCH with mem_ack, or in HOLD, SHALL move to FETCH. The acked data is discarded.
REQ-023 In DRAIN, mem_ack SHALL discard mem_rdata and go to FETCH at the current pc. A redirect in DRAIN SHALL update pc and stay in DRAIN, or go to FETCH if mem_ack is present in the same cycle.
REQ-024 pc increment SHALL wrap modulo 2^PC_W: 16'hFFFF+1=16'h0000.
REQ-025 mem_addr SHALL not change while mem_rd=1 and mem_ack=0.
REQ-026 if_valid SHALL never assert from data acked in DRAIN.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=FETCH, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
REQ-028 While rst_n=0, mem_rd SHALL be 0.
REQ-029 After rst_n rises, the first fetch SHALL request RESET_PC on the first following rising edge.
REQ-030 An outstanding request at reset SHALL be abandoned; a late mem_ack in FETCH after reset is the memory's responsibility to suppress.

Structure
REQ-031 The state encoding (2-bit localparams FETCH=0, HOLD=1, DRAIN=2) and the PC_W/INSTR_W defaults SHALL live in a shared package/defines file used by fetch, decode and the IF/ID latch.
REQ-032 One sub-module, pc_register, SHALL hold pc with load (redirect), increment, and async reset to RESET_PC. The FSM and output registers stay in fetch_stage.

Verification
REQ-033 Reset, then memory acks 1 cycle after each request with rdata=32'hA000_0000+addr, id_ready=1 -> if_pc sequence 0,1,2,3 with matching if_instr, one per 3 cycles.
REQ-034 id_ready=0 for 5 cycles while if_valid=1 at if_pc=2 -> outputs bit-stable, mem_rd=0, pc=3 unchanged.
REQ-035 Redirect to 16'h0040 while the request for 5 is outstanding -> state DRAIN, mem_addr stays 5, ack for 5 discarded, next request addr 16'h0040, first if_pc=16'h0040.
REQ-036 Redirect to 16'h0100 in the same cycle as mem_ack -> no if_valid for that ack, next mem_addr=16'h0100.
REQ-037 Redirect to 16'hFFFF, two fetches -> if_pc 16'hFFFF then 16'h0000.
REQ-038 rst_n pulsed low mid-DRAIN -> mem_rd and if_valid drop immediately (asynchronously), fetch restarts at RESET_PC.
